// File: rtl/avg_pool_feeder_pkg.sv
// Shared types for the avg-pool feeder: sample width and FSM states.
// Imported by the feeder and its bench.
package avg_pool_feeder_pkg;

  localparam int att_width = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WAIT_END,
    GAP,
    FINISH
  } feeder_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avg_pool_feeder.sv
// Streams per-channel token bursts from the attention buffer into
// Avg_pool and forwards each pooled result with its channel index.
module avg_pool_feeder
  import avg_pool_feeder_pkg::*;
#(
  parameter int N_TOKEN = 4,
  parameter int N_CH = 8,
  parameter int TIMEOUT = 64,
  localparam int ADDR_W = clog2_min1(N_CH * N_TOKEN),
  localparam int CH_W = clog2_min1(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [att_width-1:0] rd_data,
  output logic                 en,
  output logic [att_width-1:0] i_avg,
  input  logic                 end_avg,
  input  logic [att_width-1:0] o_avg,
  output logic                 res_valid,
  output logic [CH_W-1:0]      res_ch,
  output logic [att_width-1:0] res_data
);

  localparam int TOK_W = clog2_min1(N_TOKEN);
  localparam int WC_W = clog2_min1(TIMEOUT);

  localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(N_TOKEN - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  feeder_state_t state_q, state_d;

  logic [TOK_W-1:0] tok_q, tok_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic err_d;
  logic rv_d;
  logic [CH_W-1:0] rch_d;
  logic [att_width-1:0] rdat_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tok_q <= '0;
      ch_q <= '0;
      wcnt_q <= '0;
      err <= 1'b0;
      en <= 1'b0;
      res_valid <= 1'b0;
      res_ch <= '0;
      res_data <= '0;
    end else begin
      state_q <= state_d;
      tok_q <= tok_d;
      ch_q <= ch_d;
      wcnt_q <= wcnt_d;
      err <= err_d;
      en <= rd_en;
      res_valid <= rv_d;
      res_ch <= rch_d;
      res_data <= rdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tok_d = tok_q;
    ch_d = ch_q;
    wcnt_d = wcnt_q;
    err_d = err;
    rv_d = 1'b0;
    rch_d = res_ch;
    rdat_d = res_data;
    busy = 1'b0;
    done = 1'b0;
    rd_en = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          tok_d = '0;
          ch_d = '0;
          err_d = 1'b0;
        end
      end
      READ: begin
        busy = 1'b1;
        rd_en = 1'b1;
        tok_d = tok_q + 1'b1;
        if (tok_q == TOK_LAST) begin
          tok_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        wcnt_d = '0;
        state_d = WAIT_END;
      end
      WAIT_END: begin
        busy = 1'b1;
        if (end_avg) begin
          rv_d = 1'b1;
          rch_d = ch_q;
          rdat_d = o_avg;
          if (ch_q == CH_LAST) begin
            state_d = FINISH;
          end else begin
            ch_d = ch_q + 1'b1;
            state_d = GAP;
          end
        end else if (wcnt_q == WC_LAST) begin
          // Abort the whole pass; later channels are not attempted.
          err_d = 1'b1;
          state_d = FINISH;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      GAP: begin
        busy = 1'b1;
        tok_d = '0;
        state_d = READ;
      end
      FINISH: begin
        done = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (end_avg && state_q != WAIT_END) begin
      err_d = 1'b1;
    end
  end

  assign rd_addr = rd_en
    ? ADDR_W'(ch_q) * ADDR_W'(N_TOKEN) + ADDR_W'(tok_q)
    : '0;

  assign i_avg = en ? rd_data : '0;

endmodule
